// File: rtl/div_ratio_meter.sv
// div_ratio_meter: times the high and low phases of a clk-synchronous divided clock and
// reports them once per period. Lock tracking is compiled in only with `define DIV_METER_LOCK_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for the first rise after reset or overflow
// ST_HIGH | counting cycles with the sampled input high
// ST_LOW  | counting cycles with the sampled input low; next rise publishes
module div_ratio_meter #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_div_clk,
   output logic [CNT_W-1:0] o_high_cnt,
   output logic [CNT_W-1:0] o_low_cnt,
   output logic [CNT_W:0]   o_ratio,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic             r_s_d;
   logic             r_s_q;
   logic [CNT_W-1:0] r_hi;
   logic [CNT_W-1:0] r_lo;

   logic w_rise;
   logic w_pub;
   logic w_ovf;

   assign w_rise = r_s_d & ~r_s_q;
   // In ST_LOW the previous sample was low, so a high sample is always a rise.
   assign w_pub  = (r_state == ST_LOW) && r_s_d;
   assign w_ovf  = ((r_state == ST_HIGH) &&  r_s_d && (r_hi == CNT_MAX)) ||
                   ((r_state == ST_LOW)  && !r_s_d && (r_lo == CNT_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_s_d      <= 1'b0;
         r_s_q      <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         o_high_cnt <= '0;
         o_low_cnt  <= '0;
         o_ratio    <= '0;
         o_valid    <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         r_s_d   <= i_div_clk;
         r_s_q   <= r_s_d;
         o_valid <= 1'b0;
         if (w_ovf) begin
            o_err   <= 1'b1;
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_rise) begin
                     r_state <= ST_HIGH;
                     r_hi    <= CNT_ONE;
                  end
               end
               ST_HIGH: begin
                  if (r_s_d) begin
                     r_hi <= r_hi + CNT_ONE;
                  end else begin
                     r_state <= ST_LOW;
                     r_lo    <= CNT_ONE;
                  end
               end
               ST_LOW: begin
                  if (w_pub) begin
                     o_high_cnt <= r_hi;
                     o_low_cnt  <= r_lo;
                     o_ratio    <= {1'b0, r_hi} + {1'b0, r_lo};
                     o_valid    <= 1'b1;
                     o_err      <= 1'b0;
                     r_hi       <= CNT_ONE;
                     r_state    <= ST_HIGH;
                  end else begin
                     r_lo <= r_lo + CNT_ONE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef DIV_METER_LOCK_EN
   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

   logic [3:0] r_match;
   logic       r_have_prev;
   logic [3:0] w_match_inc;
   logic       w_same;

   // The outputs still hold the previously published pair at the publish edge.
   assign w_same      = (r_hi == o_high_cnt) && (r_lo == o_low_cnt);
   assign w_match_inc = r_match + 4'd1;

   always_ff @(posedge clk) begin
      if (rst || w_ovf) begin
         r_match     <= '0;
         r_have_prev <= 1'b0;
         o_locked    <= 1'b0;
      end else if (w_pub) begin
         r_have_prev <= 1'b1;
         if (!r_have_prev) begin
            r_match <= '0;
         end else if (w_same) begin
            if (r_match != LOCK_TGT) begin
               r_match <= w_match_inc;
            end
            if (w_match_inc == LOCK_TGT) begin
               o_locked <= 1'b1;
            end
         end else begin
            r_match  <= '0;
            o_locked <= 1'b0;
         end
      end
   end
`else
   // Lock logic absent; LOCK_CNT is kept only so both builds share one parameter list.
   assign o_locked = 1'b0 && (LOCK_CNT != 0);
`endif

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed bench for div_ratio_meter; lock expectations follow DIV_METER_LOCK_EN.
module tb_div_ratio_meter;

   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
`ifdef DIV_METER_LOCK_EN
   localparam int LOCK_EN = 1;
`else
   localparam int LOCK_EN = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             i_div_clk = 1'b0;
   logic [CNT_W-1:0] o_high_cnt;
   logic [CNT_W-1:0] o_low_cnt;
   logic [CNT_W:0]   o_ratio;
   logic             o_valid;
   logic             o_locked;
   logic             o_err;

   int tests = 0;
   int fails = 0;

   int   cyc = 0;
   logic err_q = 1'b0;
   int   v_cyc[$];
   int   v_hi[$];
   int   v_lo[$];
   int   v_ratio[$];
   int   v_lock[$];
   int   v_err[$];
   int   e_cyc[$];

   div_ratio_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_div_clk  (i_div_clk),
      .o_high_cnt (o_high_cnt),
      .o_low_cnt  (o_low_cnt),
      .o_ratio    (o_ratio),
      .o_valid    (o_valid),
      .o_locked   (o_locked),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc   <= cyc + 1;
      err_q <= o_err;
      if (o_valid) begin
         v_cyc.push_back(cyc);
         v_hi.push_back(int'(o_high_cnt));
         v_lo.push_back(int'(o_low_cnt));
         v_ratio.push_back(int'(o_ratio));
         v_lock.push_back(int'(o_locked));
         v_err.push_back(int'(o_err));
      end
      if (o_err && !err_q) e_cyc.push_back(cyc);
   end

   task automatic tick(input logic v);
      i_div_clk = v;
      @(posedge clk);
      #1;
   endtask

   task automatic periods(input int h, input int l, input int n);
      for (int p = 0; p < n; p++) begin
         repeat (h) tick(1'b1);
         repeat (l) tick(1'b0);
      end
   endtask

   task automatic clear_log;
      v_cyc.delete(); v_hi.delete(); v_lo.delete(); v_ratio.delete();
      v_lock.delete(); v_err.delete(); e_cyc.delete();
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick(1'b0);
      tick(1'b0);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(1'b0);
      tick(1'b0);
      tests++; if (o_high_cnt !== '0) begin fails++; $display("FAIL reset_high: got %0d expected 0", o_high_cnt); end
      tests++; if (o_low_cnt !== '0) begin fails++; $display("FAIL reset_low: got %0d expected 0", o_low_cnt); end
      tests++; if (o_ratio !== '0) begin fails++; $display("FAIL reset_ratio: got %0d expected 0", o_ratio); end
      tests++; if ({o_valid, o_locked, o_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {o_valid, o_locked, o_err}); end
      rst = 1'b0;
      clear_log();
      repeat (6) tick(1'b0);
      tests++; if (v_cyc.size() !== 0) begin fails++; $display("FAIL reset_quiet: got %0d valids expected 0", v_cyc.size()); end
   endtask

   task automatic test_div2;
      do_reset();
      periods(1, 1, 12);
      repeat (3) tick(1'b0);
      tests++; if (v_cyc.size() !== 11) begin fails++; $display("FAIL div2_count: got %0d expected 11", v_cyc.size()); end
      if (v_cyc.size() == 11) begin
         tests++; if (v_hi[0] !== 1 || v_lo[0] !== 1 || v_ratio[0] !== 2) begin fails++; $display("FAIL div2_values: got %0d/%0d/%0d expected 1/1/2", v_hi[0], v_lo[0], v_ratio[0]); end
         for (int i = 1; i < 11; i++) begin
            tests++; if (v_cyc[i] - v_cyc[i-1] !== 2) begin fails++; $display("FAIL div2_spacing[%0d]: got %0d expected 2", i, v_cyc[i] - v_cyc[i-1]); end
         end
         tests++; if (v_lock[3] !== 0) begin fails++; $display("FAIL div2_lock4: got %0d expected 0", v_lock[3]); end
         tests++; if (v_lock[4] !== LOCK_EN) begin fails++; $display("FAIL div2_lock5: got %0d expected %0d", v_lock[4], LOCK_EN); end
         tests++; if (v_lock[10] !== LOCK_EN) begin fails++; $display("FAIL div2_lock11: got %0d expected %0d", v_lock[10], LOCK_EN); end
         tests++; if (v_hi[10] !== 1 || v_ratio[10] !== 2) begin fails++; $display("FAIL div2_last: got %0d/%0d expected 1/2", v_hi[10], v_ratio[10]); end
      end
      tests++; if (e_cyc.size() !== 0) begin fails++; $display("FAIL div2_err: got %0d err rises expected 0", e_cyc.size()); end
   endtask

   task automatic test_3_5;
      do_reset();
      periods(3, 5, 6);
      repeat (2) tick(1'b0);
      tests++; if (v_cyc.size() !== 5) begin fails++; $display("FAIL p35_count: got %0d expected 5", v_cyc.size()); end
      if (v_cyc.size() == 5) begin
         tests++; if (v_hi[0] !== 3 || v_lo[0] !== 5 || v_ratio[0] !== 8) begin fails++; $display("FAIL p35_values: got %0d/%0d/%0d expected 3/5/8", v_hi[0], v_lo[0], v_ratio[0]); end
         for (int i = 1; i < 5; i++) begin
            tests++; if (v_cyc[i] - v_cyc[i-1] !== 8) begin fails++; $display("FAIL p35_spacing[%0d]: got %0d expected 8", i, v_cyc[i] - v_cyc[i-1]); end
         end
         tests++; if (v_lock[3] !== 0 || v_lock[4] !== LOCK_EN) begin fails++; $display("FAIL p35_lock: got %0d%0d expected 0%0d", v_lock[3], v_lock[4], LOCK_EN); end
      end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL p35_err: got %0d expected 0", o_err); end
   endtask

   task automatic test_relock;
      do_reset();
      periods(1, 1, 8);
      periods(2, 2, 7);
      repeat (3) tick(1'b0);
      tests++; if (v_cyc.size() !== 14) begin fails++; $display("FAIL relock_count: got %0d expected 14", v_cyc.size()); end
      if (v_cyc.size() == 14) begin
         tests++; if (v_hi[7] !== 1 || v_lock[7] !== LOCK_EN) begin fails++; $display("FAIL relock_before: got hi %0d lock %0d expected 1/%0d", v_hi[7], v_lock[7], LOCK_EN); end
         tests++; if (v_hi[8] !== 2 || v_lo[8] !== 2 || v_lock[8] !== 0) begin fails++; $display("FAIL relock_switch: got %0d/%0d lock %0d expected 2/2 lock 0", v_hi[8], v_lo[8], v_lock[8]); end
         tests++; if (v_lock[11] !== 0) begin fails++; $display("FAIL relock_pending: got %0d expected 0", v_lock[11]); end
         tests++; if (v_lock[12] !== LOCK_EN || v_ratio[12] !== 4) begin fails++; $display("FAIL relock_again: got lock %0d ratio %0d expected %0d/4", v_lock[12], v_ratio[12], LOCK_EN); end
      end
   endtask

   task automatic test_overflow;
      do_reset();
      periods(1, 1, 8);
      repeat (300) tick(1'b1);
      tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %0d expected 1", o_err); end
      tests++; if (o_locked !== 1'b0) begin fails++; $display("FAIL ovf_locked: got %0d expected 0", o_locked); end
      tests++; if (v_cyc.size() !== 8) begin fails++; $display("FAIL ovf_novalid: got %0d valids expected 8", v_cyc.size()); end
      tests++; if (o_high_cnt !== 8'd1 || o_ratio !== 9'd2) begin fails++; $display("FAIL ovf_hold: got %0d/%0d expected 1/2", o_high_cnt, o_ratio); end
      if (v_cyc.size() == 8 && e_cyc.size() == 1) begin
         tests++; if (e_cyc[0] - v_cyc[7] !== 255) begin fails++; $display("FAIL ovf_timing: got %0d expected 255", e_cyc[0] - v_cyc[7]); end
      end else begin
         tests++; fails++; $display("FAIL ovf_timing: got %0d err rises expected 1", e_cyc.size());
      end
      periods(1, 1, 4);
      repeat (3) tick(1'b0);
      tests++; if (v_cyc.size() !== 10) begin fails++; $display("FAIL ovf_resume_count: got %0d expected 10", v_cyc.size()); end
      if (v_cyc.size() == 10) begin
         tests++; if (v_ratio[8] !== 2 || v_err[8] !== 0 || v_lock[8] !== 0) begin fails++; $display("FAIL ovf_resume: got ratio %0d err %0d lock %0d expected 2/0/0", v_ratio[8], v_err[8], v_lock[8]); end
      end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got %0d expected 0", o_err); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      periods(2, 2, 8);
      tests++; if (o_locked !== LOCK_EN[0]) begin fails++; $display("FAIL rstmid_prelock: got %0d expected %0d", o_locked, LOCK_EN); end
      tick(1'b1);
      rst = 1'b1;
      tick(1'b1);
      tests++; if (o_high_cnt !== '0 || o_low_cnt !== '0 || o_ratio !== '0) begin fails++; $display("FAIL rstmid_counts: got %0d/%0d/%0d expected 0/0/0", o_high_cnt, o_low_cnt, o_ratio); end
      tests++; if ({o_valid, o_locked, o_err} !== 3'b000) begin fails++; $display("FAIL rstmid_flags: got %b expected 000", {o_valid, o_locked, o_err}); end
      rst = 1'b0;
      clear_log();
      tick(1'b0);
      tick(1'b0);
      periods(2, 2, 4);
      repeat (3) tick(1'b0);
      tests++; if (v_cyc.size() !== 3) begin fails++; $display("FAIL rstmid_count: got %0d expected 3", v_cyc.size()); end
      if (v_cyc.size() == 3) begin
         tests++; if (v_hi[0] !== 2 || v_lo[0] !== 2 || v_lock[0] !== 0) begin fails++; $display("FAIL rstmid_first: got %0d/%0d lock %0d expected 2/2 lock 0", v_hi[0], v_lo[0], v_lock[0]); end
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_div2();
      test_3_5();
      test_relock();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
